sys_arr_nxn: RTL and testbench

//  Parametrised NxN output-stationary systolic matrix multiplier: C = A*B (+ C_prev when accumulate is set).

---
 rtl/sys_arr_pkg.sv | 17 +
 rtl/sys_arr_pe.sv | 49 ++++
 rtl/sys_arr_nxn.sv | 116 +++++++++++
 tb/tb_sys_arr_nxn.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_arr_pkg.sv
// Shared types and helpers for the NxN output-stationary systolic multiplier.
// Holds the controller state encoding, default accumulator width and flat-layout indexing.
package sys_arr_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;

  // One full product pass never overflows: 2*DATA_W product bits plus log2(N) carry bits.
  function automatic int acc_w_default(input int n, input int data_w);
    return 2 * data_w + $clog2(n);
  endfunction

  // LSB of element (r,c) in a row-major flat bus of w-bit elements.
  function automatic int flat_lsb(input int r, input int c, input int n, input int w);
    return (r * n + c) * w;
  endfunction

endpackage

// File: rtl/sys_arr_pe.sv
// One processing element: multiply-accumulate, with a register each for the
// eastbound A operand and the southbound B operand.
module sys_arr_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);
  localparam int PW = 2 * DATA_W;

  logic [ACC_W-1:0] prod_ext;

  generate
    if (SIGNED != 0) begin : g_sgn
      logic signed [PW-1:0] p;
      assign p        = PW'($signed(a_in)) * PW'($signed(b_in));
      assign prod_ext = {{(ACC_W-PW){p[PW-1]}}, p};
    end else begin : g_uns
      logic [PW-1:0] p;
      assign p        = PW'(a_in) * PW'(b_in);
      assign prod_ext = {{(ACC_W-PW){1'b0}}, p};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else begin
      if (clr)     acc <= '0;
      else if (en) acc <= acc + prod_ext;
      if (en) begin
        a_out <= a_in;
        b_out <= b_in;
      end
    end
  end

endmodule

// File: rtl/sys_arr_nxn.sv
// NxN output-stationary systolic multiplier, C = A*B (+ previous C when accum is set).
// Top holds the job FSM, skew counter, operand latches, edge feed and the C register.
module sys_arr_nxn
  import sys_arr_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = acc_w_default(N, DATA_W),
  parameter int SIGNED = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    accum,
  input  logic [N*N*DATA_W-1:0]   A,
  input  logic [N*N*DATA_W-1:0]   B,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*N*ACC_W-1:0]    C
);
  localparam int K_W = $clog2(3 * N);
  // Skew counter runs 0..3N-2; the last product lands in PE(N-1,N-1) at k=3N-3,
  // so the tail of STREAM plus DRAIN gives a 3N-cycle accept-to-result latency.
  localparam logic [K_W-1:0] K_LAST = K_W'(3 * N - 2);

  state_e         state, state_nxt;
  logic [K_W-1:0] k;
  logic           accept, pe_en, pe_clr;

  logic [N-1:0][N-1:0][DATA_W-1:0] a_q, b_q;
  logic [N-1:0][N-1:0][ACC_W-1:0]  acc;
  logic [N-1:0][DATA_W-1:0]        west, north;
  logic [N-1:0][N:0][DATA_W-1:0]   a_h;
  logic [N:0][N-1:0][DATA_W-1:0]   b_v;
  logic                            unused_edge;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);
  assign pe_en     = (state == STREAM) || (state == DRAIN);
  assign pe_clr    = accept && !accum;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)    state_nxt = STREAM;
      STREAM:  if (k == K_LAST) state_nxt = DRAIN;
      DRAIN:                    state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      a_q   <= '0;
      b_q   <= '0;
      C     <= '0;
    end else begin
      state <= state_nxt;
      k     <= (state == STREAM) ? k + 1'b1 : '0;
      if (accept) begin
        a_q <= A;
        b_q <= B;
      end
      if (state == DRAIN) C <= acc;
    end
  end

  // Skewed edge feed: row i sees A[i][k-i], column j sees B[k-j][j], zero outside the matrix.
  always_comb begin
    west = '0;
    north = '0;
    if (state == STREAM) begin
      for (int i = 0; i < N; i++) begin
        for (int m = 0; m < N; m++) begin
          if (int'(k) == i + m) begin
            west[i]  = a_q[i][m];
            north[i] = b_q[m][i];
          end
        end
      end
    end
  end

  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < N; i++) unused_edge = unused_edge ^ (^a_h[i][N]) ^ (^b_v[N][i]);
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_edge
      assign a_h[i][0] = west[i];
      assign b_v[0][i] = north[i];
    end
    for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
        sys_arr_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_pe (
          .clk   (clk),
          .rst_n (rst_n),
          .clr   (pe_clr),
          .en    (pe_en),
          .a_in  (a_h[i][j]),
          .b_in  (b_v[i][j]),
          .a_out (a_h[i][j+1]),
          .b_out (b_v[i+1][j]),
          .acc   (acc[i][j])
        );
      end
    end
  endgenerate

endmodule

// File: tb/tb_sys_arr_nxn.sv
// Scoreboard bench: unsigned and signed 3x3 arrays share one stimulus stream; a
// matrix-product model predicts each C and a monitor compares on every output handshake.
module tb_sys_arr_nxn;
  import sys_arr_pkg::*;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int EW = 18;
  localparam int AW = N * N * DW;
  localparam int CW = N * N * EW;

  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, accum = 1'b0, out_rdy = 1'b1;
  logic [AW-1:0] A = '0, B = '0;
  logic          in_ready_u, in_ready_s, out_valid_u, out_valid_s;
  logic [CW-1:0] C_u, C_s;

  int            checks = 0, fails = 0;
  logic [CW-1:0] qu[$], qs[$];
  logic [EW-1:0] mu[N*N], ms[N*N];

  always #5 clk = ~clk;

  sys_arr_nxn #(.N(N), .DATA_W(DW), .ACC_W(EW), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u), .accum(accum),
    .A(A), .B(B), .out_valid(out_valid_u), .out_ready(out_rdy), .C(C_u));

  sys_arr_nxn #(.N(N), .DATA_W(DW), .ACC_W(EW), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .accum(accum),
    .A(A), .B(B), .out_valid(out_valid_s), .out_ready(out_rdy), .C(C_s));

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] fill(input logic [DW-1:0] v);
    logic [AW-1:0] f;
    for (int i = 0; i < N * N; i++) f[i*DW +: DW] = v;
    return f;
  endfunction

  function automatic logic [AW-1:0] mat_id();
    logic [AW-1:0] f;
    f = '0;
    for (int r = 0; r < N; r++) f[flat_lsb(r, r, N, DW) +: DW] = DW'(1);
    return f;
  endfunction

  function automatic logic [AW-1:0] mat_seq();
    logic [AW-1:0] f;
    for (int i = 0; i < N * N; i++) f[i*DW +: DW] = DW'(i + 1);
    return f;
  endfunction

  function automatic logic [AW-1:0] junk();
    return AW'({$urandom, $urandom, $urandom});
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N * N; i++) begin
      mu[i] = '0;
      ms[i] = '0;
    end
  endtask

  // Plain matrix product, both interpretations, accumulated modulo 2^EW.
  task automatic model_issue(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic ac);
    logic [CW-1:0] eu, es;
    int su, ss, idx;
    logic [DW-1:0] ea, eb;
    eu = '0;
    es = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        su = 0;
        ss = 0;
        for (int m = 0; m < N; m++) begin
          ea = a[flat_lsb(r, m, N, DW) +: DW];
          eb = b[flat_lsb(m, c, N, DW) +: DW];
          su += int'(ea) * int'(eb);
          ss += int'($signed(ea)) * int'($signed(eb));
        end
        idx = r * N + c;
        mu[idx] = (ac ? mu[idx] : EW'(0)) + EW'(su);
        ms[idx] = (ac ? ms[idx] : EW'(0)) + EW'(ss);
        eu[flat_lsb(r, c, N, EW) +: EW] = mu[idx];
        es[flat_lsb(r, c, N, EW) +: EW] = ms[idx];
      end
    end
    qu.push_back(eu);
    qs.push_back(es);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic ac);
    int w;
    w = 0;
    while (!(in_ready_u && in_ready_s) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) chk("in_ready_timeout", CW'(in_ready_u), CW'(1));
    A = a; B = b; accum = ac; in_valid = 1'b1;
    model_issue(a, b, ac);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = junk(); B = junk(); accum = 1'($urandom);
  endtask

  // Wait for the result handshake; optionally random out_ready and junk in_valid while busy.
  task automatic run_drain(input bit rnd, input bit jk);
    int cyc;
    bit done;
    cyc = 0;
    done = 0;
    while (!done && cyc < 100) begin
      out_rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = jk;
      if (jk) begin A = junk(); B = junk(); end
      @(negedge clk);
      if (out_valid_u && out_rdy) done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_rdy = 1'b1;
    if (!done) chk("drain_timeout", CW'(done), CW'(1));
  endtask

  task automatic latency_job();
    int cnt;
    issue(mat_id(), mat_seq(), 1'b0);
    cnt = 0;
    while (!out_valid_u && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", CW'(cnt), CW'(9));
    run_drain(0, 0);
  endtask

  // Monitor: pops the scoreboard on every output handshake of each array.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid_u && out_rdy) begin
        if (qu.size() == 0) chk("unexpected_out_u", CW'(1), CW'(0));
        else chk("C_unsigned", C_u, qu.pop_front());
      end
      if (rst_n && out_valid_s && out_rdy) begin
        if (qs.size() == 0) chk("unexpected_out_s", CW'(1), CW'(0));
        else chk("C_signed", C_s, qs.pop_front());
      end
    end
  end

  initial begin
    logic [CW-1:0] cu;
    int w;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_C_u", C_u, '0);
    chk("rst_C_s", C_s, '0);
    chk("rst_out_valid", CW'(out_valid_u), CW'(0));
    chk("rst_in_ready", CW'(in_ready_u), CW'(1));

    latency_job();

    issue(fill(8'hFF), fill(8'hFF), 1'b0);
    run_drain(0, 0);
    chk("max_unsigned_elem", CW'(C_u[flat_lsb(2, 2, N, EW) +: EW]), CW'(195075));

    issue(fill(8'hFF), fill(8'h01), 1'b0);
    run_drain(0, 0);
    chk("signed_neg3_elem", CW'(C_s[flat_lsb(1, 0, N, EW) +: EW]), CW'(18'h3FFFD));

    issue(mat_id(), mat_id(), 1'b0);
    run_drain(0, 0);
    issue(mat_id(), mat_id(), 1'b1);
    run_drain(0, 0);
    chk("accum_diag", CW'(C_u[flat_lsb(1, 1, N, EW) +: EW]), CW'(2));
    chk("accum_offdiag", CW'(C_u[flat_lsb(0, 2, N, EW) +: EW]), CW'(0));

    // Backpressure: result must hold and new requests be refused.
    out_rdy = 1'b0;
    issue(junk(), junk(), 1'b0);
    w = 0;
    while (!out_valid_u && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp_valid_rise", CW'(out_valid_u), CW'(1));
    cu = C_u;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; A = junk(); B = junk();
      @(posedge clk); #1;
      chk("bp_out_valid", CW'(out_valid_u), CW'(1));
      chk("bp_C_stable", C_u, cu);
      chk("bp_in_ready", CW'(in_ready_u), CW'(0));
    end
    in_valid = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", CW'(in_ready_u), CW'(1));
    chk("bp_release_out_valid", CW'(out_valid_u), CW'(0));
    chk("bp_C_held_idle", C_u, cu);

    // Reset at k=2 of a job: abort with no result.
    issue(junk(), junk(), 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    qu.delete();
    qs.delete();
    model_clear();
    chk("abort_out_valid", CW'(out_valid_u), CW'(0));
    chk("abort_C", C_u, '0);
    chk("abort_in_ready", CW'(in_ready_u), CW'(1));
    repeat (12) @(posedge clk);
    #1;
    latency_job();

    for (int j = 0; j < 40; j++) begin
      issue(junk(), junk(), 1'($urandom));
      run_drain(1, 1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_u_empty", CW'(qu.size()), CW'(0));
    chk("queue_s_empty", CW'(qs.size()), CW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
